// File: rtl/sar_logic.sv
// Successive-approximation controller: samples the input, then resolves N bits
// MSB-first from comparator decisions and reports the code with a one-cycle strobe.
module sar_logic #(
    parameter int N             = 16,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seq_init,
    input  logic         invert_cfg,
    input  logic         comp_valid,
    input  logic         comp_out,
    output logic         sample_en,
    output logic         comp_trig,
    output logic [N-1:0] dac_state,
    output logic         dac_drive_invert,
    output logic [N-1:0] result,
    output logic         result_valid,
    output logic         busy
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(SAMPLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_TRIG,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    dac_q, dac_d;
    logic [N-1:0]    res_q, res_d;
    logic            inv_q, inv_d;
    logic            sample_en_q, comp_trig_q, result_valid_q, busy_q;
    logic [KW-1:0]   km1;
    logic [N-1:0]    final_code;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        dac_d         = dac_q;
        res_d         = res_q;
        inv_d         = inv_q;
        km1           = k_q - KW'(1);
        final_code    = dac_q;
        final_code[0] = comp_out;

        unique case (state_q)
            S_IDLE: begin
                if (seq_init) begin
                    inv_d   = invert_cfg;
                    dac_d   = '0;
                    cnt_d   = CW'(SAMPLE_CYCLES - 1);
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == '0) begin
                    dac_d[N-1] = 1'b1;
                    k_d        = KW'(N - 1);
                    state_d    = S_TRIG;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_TRIG: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Resolve the current trial bit, then either place the next trial or finish.
                if (comp_valid) begin
                    dac_d[k_q] = comp_out;
                    if (k_q != '0) begin
                        dac_d[km1] = 1'b1;
                        k_d        = km1;
                        state_d    = S_TRIG;
                    end else begin
                        res_d   = final_code;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            cnt_q          <= '0;
            dac_q          <= '0;
            res_q          <= '0;
            inv_q          <= 1'b1;
            sample_en_q    <= 1'b0;
            comp_trig_q    <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            cnt_q          <= cnt_d;
            dac_q          <= dac_d;
            res_q          <= res_d;
            inv_q          <= inv_d;
            sample_en_q    <= (state_d == S_SAMPLE);
            comp_trig_q    <= (state_d == S_TRIG);
            result_valid_q <= (state_d == S_DONE);
            busy_q         <= (state_d != S_IDLE);
        end
    end

    assign sample_en        = sample_en_q;
    assign comp_trig        = comp_trig_q;
    assign dac_state        = dac_q;
    assign dac_drive_invert = inv_q;
    assign result           = res_q;
    assign result_valid     = result_valid_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_sar_logic.sv
// Directed bench for sar_logic: a table of conversions run through a comparator
// model, plus hand-written back-to-back start and mid-conversion reset sequences.
module tb_sar_logic;

    localparam int N   = 16;
    localparam int S   = 2;
    localparam int LAT = S + 2 * N + 1;
    localparam int NV  = 6;

    typedef struct {
        logic [15:0] target;
        int          maxDelay;
        bit          spurious;
        bit          invCfg;
        int          pulseAt;
        logic [15:0] expResult;
    } vec_t;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          seq_init   = 1'b0;
    logic          invert_cfg = 1'b1;
    logic          comp_valid = 1'b0;
    logic          comp_out   = 1'b0;
    logic          sample_en;
    logic          comp_trig;
    logic [N-1:0]  dac_state;
    logic          dac_drive_invert;
    logic [N-1:0]  result;
    logic          result_valid;
    logic          busy;

    int            checks  = 0;
    int            errors  = 0;
    int            rvCount = 0;
    logic [15:0]   trialLog [N];
    vec_t          vecs [NV];

    sar_logic #(.N(N), .SAMPLE_CYCLES(S)) dut (
        .clk              (clk),
        .rst              (rst),
        .seq_init         (seq_init),
        .invert_cfg       (invert_cfg),
        .comp_valid       (comp_valid),
        .comp_out         (comp_out),
        .sample_en        (sample_en),
        .comp_trig        (comp_trig),
        .dac_state        (dac_state),
        .dac_drive_invert (dac_drive_invert),
        .result           (result),
        .result_valid     (result_valid),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) rvCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One conversion from an idle DUT; comparator answers dly+1 cycles after each trigger.
    task automatic applyStimulus(input logic [15:0] target, input int maxDelay, input bit spurious,
                                 input bit invCfg, input int pulseAt, input bit hold,
                                 output int lat, output int trigs, output logic [15:0] res,
                                 output logic [15:0] dacEnd, output int extra, output int invErr);
        int cyc;
        int waitCnt;
        int dly;
        bit done;
        lat = -1; trigs = 0; res = '0; dacEnd = '0; extra = 0; invErr = 0;
        cyc = 0; waitCnt = 0; done = 1'b0;
        @(negedge clk);
        checkOutput("idle before start", 32'(busy), 32'd0);
        seq_init   = 1'b1;
        invert_cfg = invCfg;
        comp_valid = spurious;
        comp_out   = 1'b1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (dac_drive_invert !== invCfg) invErr++;
            if (result_valid) begin
                lat    = cyc;
                res    = result;
                dacEnd = dac_state;
                done   = 1'b1;
            end
            if (waitCnt > 0) begin
                waitCnt--;
                comp_valid = (waitCnt == 0);
                comp_out   = (waitCnt == 0) ? (dac_state <= target) : 1'b0;
            end else if (spurious && (comp_trig || sample_en)) begin
                comp_valid = 1'b1;
                comp_out   = 1'($urandom);
            end else begin
                comp_valid = 1'b0;
            end
            if (comp_trig) begin
                if (trigs < N) trialLog[trigs] = dac_state;
                trigs++;
                dly = (maxDelay > 0) ? int'($urandom_range(32'(maxDelay), 0)) : 0;
                extra  += dly;
                waitCnt = dly + 1;
            end
            invert_cfg = ~invert_cfg;
            seq_init   = hold ? 1'b1 : (cyc == pulseAt);
        end
        comp_valid = 1'b0;
        checkOutput("conversion completes", 32'(done), 32'd1);
    endtask

    initial begin
        int          lat;
        int          trigs;
        int          extra;
        int          invErr;
        int          trialErr;
        int          cyc;
        int          waitCnt;
        int          rvBefore;
        logic [15:0] res;
        logic [15:0] dacEnd;
        logic [15:0] keepMask;
        logic [15:0] expTrial;

        vecs[0] = '{16'hA5C3, 0, 1'b0, 1'b1, -1, 16'hA5C3};
        vecs[1] = '{16'hFFFF, 0, 1'b0, 1'b1, -1, 16'hFFFF};
        vecs[2] = '{16'h0000, 0, 1'b0, 1'b1, -1, 16'h0000};
        vecs[3] = '{16'h1234, 7, 1'b1, 1'b1, -1, 16'h1234};
        vecs[4] = '{16'h8000, 3, 1'b1, 1'b0, -1, 16'h8000};
        vecs[5] = '{16'h7FFF, 0, 1'b0, 1'b1, 10, 16'h7FFF};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset sample_en", 32'(sample_en), 32'd0);
        checkOutput("reset comp_trig", 32'(comp_trig), 32'd0);
        checkOutput("reset dac_state", 32'(dac_state), 32'd0);
        checkOutput("reset dac_drive_invert", 32'(dac_drive_invert), 32'd1);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset result_valid", 32'(result_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].target, vecs[i].maxDelay, vecs[i].spurious, vecs[i].invCfg,
                          vecs[i].pulseAt, 1'b0, lat, trigs, res, dacEnd, extra, invErr);
            checkOutput($sformatf("v%0d result", i), 32'(res), 32'(vecs[i].expResult));
            checkOutput($sformatf("v%0d latency", i), lat, LAT + extra);
            checkOutput($sformatf("v%0d trigger count", i), trigs, N);
            checkOutput($sformatf("v%0d dac_state at done", i), 32'(dacEnd), 32'(vecs[i].expResult));
            checkOutput($sformatf("v%0d invert held", i), invErr, 0);
            trialErr = 0;
            for (int j = 0; j < N; j++) begin
                keepMask = 16'(32'hFFFF_0000 >> j);
                expTrial = (vecs[i].target & keepMask) | (16'h8000 >> j);
                if (trialLog[j] !== expTrial) trialErr++;
            end
            checkOutput($sformatf("v%0d trial sequence", i), trialErr, 0);
            @(negedge clk);
            checkOutput($sformatf("v%0d strobe one cycle", i), 32'(result_valid), 32'd0);
            checkOutput($sformatf("v%0d idle after done", i), 32'(busy), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("v%0d no restart", i), 32'(busy), 32'd0);
            checkOutput($sformatf("v%0d dac_state holds", i), 32'(dac_state), 32'(vecs[i].expResult));
            checkOutput($sformatf("v%0d result holds", i), 32'(result), 32'(vecs[i].expResult));
        end

        // seq_init held high: the second start is accepted on the first IDLE cycle.
        applyStimulus(16'h5A5A, 0, 1'b0, 1'b1, -1, 1'b1, lat, trigs, res, dacEnd, extra, invErr);
        checkOutput("b2b first latency", lat, LAT);
        checkOutput("b2b first result", 32'(res), 32'h5A5A);
        applyStimulus(16'hC3A5, 0, 1'b0, 1'b1, -1, 1'b1, lat, trigs, res, dacEnd, extra, invErr);
        seq_init = 1'b0;
        checkOutput("b2b second latency", lat, LAT);
        checkOutput("b2b second result", 32'(res), 32'hC3A5);
        checkOutput("b2b second triggers", trigs, N);

        // Reset while waiting on the comparator for bit 7.
        @(negedge clk);
        @(negedge clk);
        seq_init   = 1'b1;
        invert_cfg = 1'b0;
        trigs = 0; waitCnt = 0; cyc = 0;
        rvBefore = rvCount;
        while (trigs < 9 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            seq_init = 1'b0;
            if (waitCnt > 0) begin
                waitCnt--;
                comp_valid = (waitCnt == 0);
                comp_out   = (dac_state <= 16'h3C5A);
            end else begin
                comp_valid = 1'b0;
            end
            if (comp_trig) begin
                trigs++;
                if (trigs < 9) waitCnt = 1;
            end
        end
        comp_valid = 1'b0;
        checkOutput("rst seq trigger count", trigs, 9);
        @(negedge clk);
        checkOutput("rst seq busy in wait", 32'(busy), 32'd1);
        checkOutput("rst seq trial at k7", 32'(dac_state), 32'h3C80);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst sample_en", 32'(sample_en), 32'd0);
        checkOutput("async rst comp_trig", 32'(comp_trig), 32'd0);
        checkOutput("async rst dac_state", 32'(dac_state), 32'd0);
        checkOutput("async rst dac_drive_invert", 32'(dac_drive_invert), 32'd1);
        checkOutput("async rst result", 32'(result), 32'd0);
        checkOutput("async rst result_valid", 32'(result_valid), 32'd0);
        checkOutput("async rst busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("no strobe after reset", rvCount, rvBefore);
        checkOutput("idle after reset", 32'(busy), 32'd0);

        applyStimulus(16'h3C5A, 2, 1'b0, 1'b1, -1, 1'b0, lat, trigs, res, dacEnd, extra, invErr);
        checkOutput("post-reset result", 32'(res), 32'h3C5A);
        checkOutput("post-reset latency", lat, LAT + extra);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
